// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply.
// Command in via valid/ready, result held in DONE until the consumer takes it.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and payload is stable while valid waits.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] C_ADD = 4'd0,  C_SUB = 4'd1,  C_XOR = 4'd2,  C_SLT = 4'd3;
  localparam logic [3:0] C_AND = 4'd4,  C_NAND = 4'd5, C_OR = 4'd6,   C_NOR = 4'd7;
  localparam logic [3:0] C_SLL = 4'd8,  C_SRL = 4'd9,  C_SRA = 4'd10, C_MUL = 4'd11;

  logic [1:0]       state_q, state_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v, sub_v;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] alu_res, acc_step;
  logic             alu_c, alu_v, alu_ill;
  logic             accept;

  assign in_ready    = rdy_en_q && (state_q == S_IDLE);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign carryout    = carry_q;
  assign overflow    = ovf_q;
  assign illegal     = ill_q;
  assign zero        = (result_q == '0);
  assign dbg_state_o = state_q;
  assign amt         = b[SHW-1:0];
  assign acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    add_s   = {1'b0, a} + {1'b0, b};
    sub_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
    sub_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (cmd)
      C_ADD:  begin alu_res = add_s[WIDTH-1:0]; alu_c = add_s[WIDTH]; alu_v = add_v; end
      C_SUB:  begin alu_res = sub_s[WIDTH-1:0]; alu_c = sub_s[WIDTH]; alu_v = sub_v; end
      C_XOR:  alu_res = a ^ b;
      C_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_v};
      C_AND:  alu_res = a & b;
      C_NAND: alu_res = ~(a & b);
      C_OR:   alu_res = a | b;
      C_NOR:  alu_res = ~(a | b);
      C_SLL:  alu_res = a << amt;
      C_SRL:  alu_res = a >> amt;
      C_SRA:  alu_res = $signed(a) >>> amt;
      C_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          carry_d = alu_c;
          ovf_d   = alu_v;
          ill_d   = alu_ill;
          if (cmd == C_MUL) begin
            // First shift-add step happens in the accept cycle so the result
            // lands WIDTH cycles after acceptance, like the 1-cycle ops.
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
            cnt_d    = {{(SHW-1){1'b0}}, 1'b1};
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = acc_step;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=32) with hand-computed expectations.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [3:0]   cmd;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, carryout, overflow, zero, illegal;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for one cycle; returns in the cycle after acceptance.
  task automatic issue(input string tag, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    check({tag, "_in_ready"}, in_ready, 1);
    cmd = c; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cmd = 4'd0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ec, input logic ev, input logic ei);
    issue(tag, c, x, y);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carryout, ec);
    check({tag, "_ovf"}, overflow, ev);
    check({tag, "_zero"}, zero, (er == '0));
    check({tag, "_illegal"}, illegal, ei);
    drain(tag);
  endtask

  // Keeps a stray ADD request asserted during the multiply to show it is dropped.
  task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] er);
    int cycles;
    int ready_seen;
    issue(tag, 4'd11, x, y);
    cmd = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    cycles = 1;
    ready_seen = 0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) ready_seen++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, cycles, W);
    check({tag, "_ready_low"}, ready_seen, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carryout, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_illegal"}, illegal, 0);
    drain(tag);
    tick();
    check({tag, "_no_stray"}, out_valid, 0);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cmd = '0; a = '0; b = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_flags", {carryout, overflow, illegal}, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);

    // out_ready with nothing held must not disturb anything
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("idle_oready_ov", out_valid, 0);
    check("idle_oready_rdy", in_ready, 1);

    run_op("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0);
    run_op("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0);
    run_op("sub_ovf",   4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1, 1, 0);
    run_op("sub_borrow",4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 0, 0, 0);
    run_op("slt_ovf",   4'd3,  32'h8000_0000, 32'h1,         32'h1,         0, 0, 0);
    run_op("slt_neg",   4'd3,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0);
    run_op("slt_false", 4'd3,  32'h1,         32'hFFFF_FFFF, 32'h0,         0, 0, 0);
    run_op("xor",       4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0);
    run_op("and",       4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0);
    run_op("nand",      4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 0, 0, 0);
    run_op("or",        4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0);
    run_op("nor",       4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, 0, 0);
    run_op("sll",       4'd8,  32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 0, 0, 0);
    run_op("sll_amt0",  4'd8,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 0, 0, 0);
    run_op("sra",       4'd10, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 0, 0, 0);
    run_op("srl",       4'd9,  32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 0, 0, 0);
    run_op("illegal13", 4'd13, 32'h1234_5678, 32'h1,         32'h0,         0, 0, 1);
    run_op("illegal15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, 0, 1);

    run_mul("mul_a", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    run_mul("mul_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Backpressure: result held while the consumer stalls
    issue("bp", 4'd0, 32'd2, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 5);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    drain("bp");

    // Reset in the middle of a multiply
    issue("mul_rst", 4'd11, 32'd3, 32'd3);
    repeat (9) tick();
    check("mul_rst_busy", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check("mul_rst_ov", out_valid, 0);
    check("mul_rst_rdy_low", in_ready, 0);
    check("mul_rst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("mul_rst_rdy", in_ready, 1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stray++;
      tick();
    end
    check("mul_rst_no_result", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width; it is derived and is not overridden.
REQ-003 clk  input  1  The single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  Reset: asynchronous assert, active-low.
REQ-005 in_valid  input  1  A command is presented.
REQ-006 in_ready  output  1  The block can accept a command.
REQ-007 cmd  input  4  Operation code.
REQ-008 a  input  WIDTH  Operand A.
REQ-009 b  input  WIDTH  Operand B.
REQ-010 out_valid  output  1  A result is held.
REQ-011 out_ready  input  1  The consumer takes the result.
REQ-012 result  output  WIDTH  Operation result.
REQ-013 carryout  output  1  Adder carry; ADD/SUB only.
REQ-014 overflow  output  1  Signed overflow; ADD/SUB only.
REQ-015 zero  output  1  result == 0.
REQ-016 illegal  output  1  cmd was not defined.

Function
REQ-017 The cmd encoding SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 OR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 MUL; codes 12-15 are illegal.
REQ-018 The FSM SHALL have three states, IDLE, MUL and DONE; in_ready SHALL equal (state==IDLE).
REQ-019 A command SHALL be accepted on a rising edge with in_valid && in_ready; a, b and cmd are captured and no longer need to be held.
REQ-020 For cmd 0-10 and 12-15, IDLE SHALL go to DONE on acceptance, giving out_valid in the next cycle (latency 1).
REQ-021 For MUL, IDLE SHALL go to MUL, run WIDTH shift-add iterations, one per cycle, then go to DONE; out_valid SHALL rise exactly WIDTH cycles after acceptance.
REQ-022 MUL SHALL return the low WIDTH bits of the unsigned product, with carryout=overflow=0.
REQ-023 DONE SHALL hold result and all flags stable until out_valid && out_ready, then go to IDLE on that edge; in_ready is therefore high the following cycle.
REQ-024 SUB SHALL compute a + ~b + 1; carryout SHALL be the adder carry out of bit WIDTH-1 (1 = no borrow); overflow SHALL be the two's-complement signed overflow.
REQ-025 SLT SHALL give result = {WIDTH-1 zeros, (a-b)[MSB] XOR overflow}, with carryout=overflow=0.
REQ-026 NAND and NOR SHALL be the bitwise inverses of AND and OR.
REQ-027 Shifts SHALL use b[SHW-1:0] as the amount and ignore the upper bits of b; SRA sign-fills from a[WIDTH-1]; an amount of 0 returns a.
REQ-028 carryout and overflow SHALL be 0 for every cmd other than ADD/SUB.
REQ-029 zero SHALL be computed from the registered result.
REQ-030 An illegal cmd SHALL give result=0, zero=1, illegal=1, with 1-cycle latency; illegal SHALL be 0 for legal commands.
REQ-031 in_valid while not in IDLE SHALL be ignored, without being captured or queued.
REQ-032 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-033 While rst_n=0: state=IDLE, out_valid=0, result=0, carryout=0, overflow=0, illegal=0, zero=1, the MUL iteration counter=0.
REQ-034 in_ready SHALL be 0 while rst_n=0 and 1 from the first clock after release.
REQ-035 Reset asserted mid-MUL or in DONE SHALL abort immediately, with no output produced afterwards for that command.

Verification
REQ-036 WIDTH=32: ADD a=0xFFFFFFFF, b=1 -> one cycle later out_valid=1, result=0, carryout=1, overflow=0, zero=1.
REQ-037 SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1, carryout=1; SLT with the same operands -> result=1.
REQ-038 MUL a=0x0001_0003, b=0x0000_0005 -> out_valid exactly 32 cycles after acceptance, result=0x0005_000F; in_ready stays 0 throughout, and a second in_valid during MUL is dropped.
REQ-039 SRA a=0x80000000, b=0xFFFFFFE4 (amount 4) -> result=0xF8000000; SRL with the same operands -> 0x08000000.
REQ-040 Backpressure: ADD 2+3 with out_ready=0 for 5 cycles -> result=5 held stable and in_ready=0; out_ready=1 -> out_valid drops next cycle and in_ready=1.
REQ-041 cmd=13 -> illegal=1, result=0; rst_n pulsed low at MUL cycle 10 -> out_valid=0 and in_ready=1 after release, with no spurious result.
